// File: rtl/run_detector_pkg.sv
// Shared types and width helper for the run-length detector.
package run_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    // Width that holds a run count of 0..run_len.
    function automatic int run_len_w(int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// Stream/status bundle between the serial sampler and the run detector.
interface run_detector_if #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
);
    import run_detector_pkg::*;

    localparam int RW = run_len_w(RUN_LEN);

    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             overlap;
    logic             hit;
    logic             hit_sym;
    logic [RW-1:0]    run_len;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output clear, in_valid, in_bit, overlap,
        input  hit, hit_sym, run_len, hit_count
    );

    modport slave (
        input  clear, in_valid, in_bit, overlap,
        output hit, hit_sym, run_len, hit_count
    );
endinterface

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != {W{1'b1}}))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive equal accepted bits; restart or overlapping hits.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    run_detector_if.slave  bus
);
    localparam int RW = run_len_w(RUN_LEN);

    state_t           state_q;
    logic [RW-1:0]    cnt_q;
    logic             cur_sym_q;
    logic             hit_q;
    logic             hit_sym_q;
    logic [CNT_W-1:0] hit_count_w;

    logic accept, same, hit_d;

    assign accept = bus.in_valid && !bus.clear;
    assign same   = (bus.in_bit == cur_sym_q);

    // A hit either completes a run from RUN or extends one in overlap mode.
    always_comb begin
        hit_d = 1'b0;
        if (accept && same) begin
            if (state_q == RUN && cnt_q == RW'(RUN_LEN - 1))
                hit_d = 1'b1;
            else if (state_q == HIT && bus.overlap)
                hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sym_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_sym_q <= 1'b0;
        end else if (bus.clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sym_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_sym_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
            if (hit_d)
                hit_sym_q <= cur_sym_q;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    state_q   <= RUN;
                    cur_sym_q <= bus.in_bit;
                    cnt_q     <= RW'(1);
                end
                RUN: if (bus.in_valid) begin
                    if (!same) begin
                        cur_sym_q <= bus.in_bit;
                        cnt_q     <= RW'(1);
                    end else if (hit_d) begin
                        state_q <= HIT;
                        cnt_q   <= RW'(RUN_LEN);
                    end else begin
                        cnt_q <= cnt_q + RW'(1);
                    end
                end
                HIT: if (bus.in_valid && !hit_d) begin
                    state_q   <= RUN;
                    cur_sym_q <= bus.in_bit;
                    cnt_q     <= RW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .inc   (hit_d),
        .q     (hit_count_w)
    );

    assign bus.hit       = hit_q;
    assign bus.hit_sym   = hit_sym_q;
    assign bus.run_len   = cnt_q;
    assign bus.hit_count = hit_count_w;
endmodule

// File: tb/tb_run_detector.sv
// Directed bench: two detectors (CNT_W=8 and CNT_W=2) against a run-length model.
module tb_run_detector;
    localparam int L = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    run_detector_if #(.RUN_LEN(L), .CNT_W(8)) ba ();
    run_detector_if #(.RUN_LEN(L), .CNT_W(2)) bb ();

    run_detector #(.RUN_LEN(L), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ba));
    run_detector #(.RUN_LEN(L), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bb));

    // Model: length of the current run of equal accepted bits, capped at L.
    typedef struct {
        int run;
        bit sym;
        bit done;
        bit hit;
        bit hsym;
        int cnt;
    } model_t;

    localparam model_t M0 = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    function automatic model_t step(model_t m, bit b, bit ov, int cmax);
        model_t n = m;
        if (m.run > 0 && b == m.sym && !(m.done && !ov))
            n.run = (m.run + 1 > L) ? L : m.run + 1;
        else
            n.run = 1;
        n.sym  = b;
        n.hit  = (n.run == L);
        n.done = n.hit;
        if (n.hit) begin
            n.hsym = b;
            if (n.cnt < cmax) n.cnt = n.cnt + 1;
        end
        return n;
    endfunction

    model_t ma = M0, mb = M0;

    logic clear, in_valid, in_bit, overlap;
    assign ba.clear = clear;  assign ba.in_valid = in_valid;
    assign ba.in_bit = in_bit; assign ba.overlap = overlap;
    assign bb.clear = clear;  assign bb.in_valid = in_valid;
    assign bb.in_bit = in_bit; assign bb.overlap = overlap;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= M0;
            mb <= M0;
        end else if (clear) begin
            ma <= M0;
            mb <= M0;
        end else if (in_valid) begin
            ma <= step(ma, in_bit, overlap, 255);
            mb <= step(mb, in_bit, overlap, 3);
        end else begin
            ma.hit <= 1'b0;
            mb.hit <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a.hit",       int'(ba.hit),       int'(ma.hit));
        chk("a.hit_sym",   int'(ba.hit_sym),   int'(ma.hsym));
        chk("a.run_len",   int'(ba.run_len),   ma.run);
        chk("a.hit_count", int'(ba.hit_count), ma.cnt);
        chk("b.hit",       int'(bb.hit),       int'(mb.hit));
        chk("b.hit_sym",   int'(bb.hit_sym),   int'(mb.hsym));
        chk("b.run_len",   int'(bb.run_len),   mb.run);
        chk("b.hit_count", int'(bb.hit_count), mb.cnt);
    end

    task automatic zeros(input string tag);
        chk({tag, ".hit"},     int'(ba.hit),       0);
        chk({tag, ".hit_sym"}, int'(ba.hit_sym),   0);
        chk({tag, ".run_len"}, int'(ba.run_len),   0);
        chk({tag, ".count"},   int'(ba.hit_count), 0);
        chk({tag, ".b_run"},   int'(bb.run_len),   0);
        chk({tag, ".b_count"}, int'(bb.hit_count), 0);
    endtask

    // Called at posedge+1; leaves in_valid high for back-to-back bits.
    task automatic send(input bit b, input bit ov, input int exp_run, input bit exp_hit);
        in_valid = 1'b1; in_bit = b; overlap = ov;
        @(posedge clk); #1;
        chk("seq.run_len", int'(ba.run_len), exp_run);
        chk("seq.hit",     int'(ba.hit),     int'(exp_hit));
    endtask

    task automatic gap(input int n, input int exp_run);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("gap.hit",     int'(ba.hit),     0);
            chk("gap.run_len", int'(ba.run_len), exp_run);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1; overlap = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; overlap = 1'b0;
        zeros("clear");
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b0;
        #3;
        zeros("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Restart mode: six zeros
        send(0, 0, 1, 0); send(0, 0, 2, 0); send(0, 0, 3, 1);
        send(0, 0, 1, 0); send(0, 0, 2, 0); send(0, 0, 3, 1);
        chk("s1.count", int'(ba.hit_count), 2);
        chk("s1.sym",   int'(ba.hit_sym),   0);
        chk("s1.model", ma.cnt,             2);
        gap(1, 3);
        do_clear();

        // Overlap mode: six zeros
        send(0, 1, 1, 0); send(0, 1, 2, 0); send(0, 1, 3, 1);
        send(0, 1, 3, 1); send(0, 1, 3, 1); send(0, 1, 3, 1);
        chk("s2.count",   int'(ba.hit_count), 4);
        chk("s2.b_count", int'(bb.hit_count), 3);
        gap(1, 3);
        do_clear();

        // Mismatch restarts the run
        send(0, 0, 1, 0); send(0, 0, 2, 0); send(1, 0, 1, 0);
        send(1, 0, 2, 0); send(1, 0, 3, 1);
        chk("s3.sym",   int'(ba.hit_sym),   1);
        chk("s3.count", int'(ba.hit_count), 1);
        gap(2, 3);
        chk("s3.sym_hold", int'(ba.hit_sym), 1);
        do_clear();

        // Gapped valid
        send(1, 0, 1, 0); gap(2, 1);
        send(1, 0, 2, 0); gap(2, 2);
        send(1, 0, 3, 1); gap(2, 3);
        chk("s4.count", int'(ba.hit_count), 1);
        do_clear();

        // Saturation on the 2-bit counter
        for (int i = 1; i <= 7; i++)
            send(1, 1, (i < L) ? i : L, i >= L);
        chk("s5.count",   int'(ba.hit_count), 5);
        chk("s5.b_count", int'(bb.hit_count), 3);
        chk("s5.b_hit",   int'(bb.hit),       1);
        chk("s5.model_b", mb.cnt,             3);
        gap(1, 3);
        do_clear();

        // Asynchronous reset mid-run
        send(0, 0, 1, 0); send(0, 0, 2, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 zeros("async");
        #2 reset = 1'b0;
        @(posedge clk); #1;
        send(0, 0, 1, 0);
        gap(1, 1);

        // Same with synchronous clear
        do_clear();
        send(0, 0, 1, 0); send(0, 0, 2, 0);
        do_clear();
        send(0, 0, 1, 0);
        gap(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
